// File: rtl/axi_rd_arb.sv
// axi_rd_arb: two-requester AXI3 read arbiter.
// Round-robin AR arbitration with a per-port outstanding-burst limit, ARID
// tagging with the port number, and RID-based steering of read beats.
// Optional build macro RDARB_STATS_EN adds per-port beat counters and an
// AR stall indicator.
module axi_rd_arb #(
   parameter int MAXOUT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m0_araddr,
   input  logic [3:0]  m0_arlen,
   input  logic        m0_arvalid,
   output logic        m0_arready,
   output logic [63:0] m0_rdata,
   output logic        m0_rlast,
   output logic        m0_rvalid,
   input  logic [31:0] m1_araddr,
   input  logic [3:0]  m1_arlen,
   input  logic        m1_arvalid,
   output logic        m1_arready,
   output logic [63:0] m1_rdata,
   output logic        m1_rlast,
   output logic        m1_rvalid,
   output logic [31:0] araddr,
   output logic [5:0]  arid,
   output logic [3:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   input  logic [63:0] rdata,
   input  logic [5:0]  rid,
   input  logic        rlast,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready
`ifdef RDARB_STATS_EN
   ,
   output logic [31:0] beats0,
   output logic [31:0] beats1,
   output logic        stall
`endif
);

   typedef enum logic {S_IDLE, S_ISSUE} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_araddr;
   logic [3:0]  r_arlen;
   logic        r_arvalid;
   // Port owning the current burst; doubles as the last-grant pointer.
   logic        r_gnt;
   logic        w_load;
   logic        w_sel;
   logic        w_hs;
   logic [2:0]  r_out [2];
   logic [1:0]  w_elig;
   logic [1:0]  w_inc;
   logic [1:0]  w_dec;
   logic        w_unused;

   // Response status and the upper ID bits carry no routing information.
   assign w_unused = ^{rresp, rid[5:1]};

   assign w_hs      = r_arvalid && arready;
   assign w_elig[0] = m0_arvalid && (r_out[0] < 3'(MAXOUT));
   assign w_elig[1] = m1_arvalid && (r_out[1] < 3'(MAXOUT));

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state and grant decision; ties go to the port not granted last.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_sel       = r_gnt;
      case (r_state)
         S_IDLE: begin
            if (w_elig[0] || w_elig[1]) begin
               w_load      = 1'b1;
               w_state_nxt = S_ISSUE;
               if (w_elig[0] && w_elig[1]) w_sel = ~r_gnt;
               else                        w_sel = w_elig[1];
            end
         end
         S_ISSUE: begin
            if (w_hs) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // AR channel registers: latch the winner at grant, hold until handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_arvalid <= 1'b0;
         r_gnt     <= 1'b1;
         r_araddr  <= '0;
         r_arlen   <= '0;
      end else if (w_load) begin
         r_arvalid <= 1'b1;
         r_gnt     <= w_sel;
         r_araddr  <= w_sel ? m1_araddr : m0_araddr;
         r_arlen   <= w_sel ? m1_arlen  : m0_arlen;
      end else if (w_hs) begin
         r_arvalid <= 1'b0;
      end
   end

   // Per-port outstanding burst counters.
   for (genvar n = 0; n < 2; n++) begin : g_out
      assign w_inc[n] = w_hs && (r_gnt == 1'(n));
      assign w_dec[n] = rvalid && rlast && (rid[0] == 1'(n));

      // Simultaneous issue and retire cancel; a stray retire at zero is dropped.
      always_ff @(posedge clk) begin
         if (reset)
            r_out[n] <= '0;
         else if (w_inc[n] && !w_dec[n])
            r_out[n] <= r_out[n] + 3'd1;
         else if (w_dec[n] && !w_inc[n] && (r_out[n] != 3'd0))
            r_out[n] <= r_out[n] - 3'd1;
      end
   end

   assign araddr     = r_araddr;
   assign arlen      = r_arlen;
   assign arid       = {5'b0, r_gnt};
   assign arvalid    = r_arvalid;
   assign arsize     = 3'd3;
   assign arburst    = 2'd1;
   assign rready     = 1'b1;
   assign m0_arready = w_hs && !r_gnt;
   assign m1_arready = w_hs &&  r_gnt;

   // Shared read data bus; valid/last steered by the port bit of RID.
   assign m0_rdata  = rdata;
   assign m1_rdata  = rdata;
   assign m0_rvalid = rvalid && !rid[0];
   assign m1_rvalid = rvalid &&  rid[0];
   assign m0_rlast  = rlast  && !rid[0];
   assign m1_rlast  = rlast  &&  rid[0];

`ifdef RDARB_STATS_EN
   logic [31:0] r_beats0;
   logic [31:0] r_beats1;

   // Delivered-beat counters, wrapping naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_beats0 <= '0;
         r_beats1 <= '0;
      end else begin
         if (m0_rvalid) r_beats0 <= r_beats0 + 32'd1;
         if (m1_rvalid) r_beats1 <= r_beats1 + 32'd1;
      end
   end

   assign beats0 = r_beats0;
   assign beats1 = r_beats1;
   assign stall  = r_arvalid && !arready;
`endif

endmodule

// File: tb/tb_axi_rd_arb.sv
// Bench for axi_rd_arb: directed scenarios plus a randomized run against a
// transaction-level reference model.
module tb_axi_rd_arb;
   localparam int MAXOUT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] m0_araddr, m1_araddr;
   logic [3:0]  m0_arlen, m1_arlen;
   logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
   logic [63:0] m0_rdata, m1_rdata;
   logic        m0_rlast, m1_rlast, m0_rvalid, m1_rvalid;
   logic [31:0] araddr;
   logic [5:0]  arid;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid, arready;
   logic [63:0] rdata;
   logic [5:0]  rid;
   logic        rlast, rvalid, rready;
   logic [1:0]  rresp;
`ifdef RDARB_STATS_EN
   logic [31:0] beats0, beats1;
   logic        stall;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   axi_rd_arb #(.MAXOUT(MAXOUT)) dut (
      .clk(clk), .reset(reset),
      .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
      .m0_rdata(m0_rdata), .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid),
      .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
      .m1_rdata(m1_rdata), .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid),
      .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready), .rdata(rdata), .rid(rid), .rlast(rlast),
      .rresp(rresp), .rvalid(rvalid), .rready(rready)
`ifdef RDARB_STATS_EN
      , .beats0(beats0), .beats1(beats1), .stall(stall)
`endif
   );

   task automatic nxt();
      @(posedge clk); #1;
   endtask

   task automatic drive_idle();
      m0_araddr = 0; m0_arlen = 0; m0_arvalid = 0;
      m1_araddr = 0; m1_arlen = 0; m1_arvalid = 0;
      arready = 0; rdata = 0; rid = 0; rlast = 0; rresp = 0; rvalid = 0;
   endtask

   task automatic do_reset();
      reset = 1; drive_idle(); nxt(); nxt(); reset = 0;
   endtask

   task automatic test_reset();
      reset = 1; drive_idle(); m0_arvalid = 1; m1_arvalid = 1; arready = 1;
      nxt(); nxt(); #3;
      total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid act=%0h exp=0", arvalid); end
      total++; if (m0_arready !== 1'b0) begin bad++; $display("FAIL rst_m0_arready act=%0h exp=0", m0_arready); end
      total++; if (m1_arready !== 1'b0) begin bad++; $display("FAIL rst_m1_arready act=%0h exp=0", m1_arready); end
      total++; if ({arsize, arburst, rready} !== {3'd3, 2'd1, 1'b1}) begin bad++;
         $display("FAIL rst_consts act=%0h/%0h/%0h exp=3/1/1", arsize, arburst, rready); end
      nxt(); reset = 0; drive_idle();
   endtask

   task automatic test_single();
      int pulses = 0;
      logic [63:0] d;
      do_reset();
      m0_araddr = 32'h1000; m0_arlen = 4'd15; m0_arvalid = 1; arready = 0;
      #3;
      total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL single_pregrant act=%0h exp=0", arvalid); end
      nxt();
      for (int i = 0; i < 3; i++) begin
         #3;
         total++; if ({arvalid, araddr, arid, arlen} !== {1'b1, 32'h1000, 6'd0, 4'd15}) begin bad++;
            $display("FAIL single_hold act=%0h/%0h/%0h/%0h exp=1/1000/0/f", arvalid, araddr, arid, arlen); end
         pulses += int'(m0_arready);
         nxt();
      end
      arready = 1; #3;
      pulses += int'(m0_arready);
      total++; if (m1_arready !== 1'b0) begin bad++; $display("FAIL single_m1_arready act=%0h exp=0", m1_arready); end
      nxt();
      m0_arvalid = 0; arready = 0; #3;
      pulses += int'(m0_arready);
      total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL single_arvalid_drop act=%0h exp=0", arvalid); end
      total++; if (pulses != 1) begin bad++; $display("FAIL single_pulses act=%0d exp=1", pulses); end
      nxt();
      for (int b = 0; b < 16; b++) begin
         d = {$urandom, $urandom};
         rvalid = 1; rid = 0; rlast = (b == 15); rdata = d; #3;
         total++;
         if ({m0_rvalid, m1_rvalid, m0_rlast, m1_rlast, m0_rdata} !== {1'b1, 1'b0, (b == 15), 1'b0, d}) begin bad++;
            $display("FAIL single_beat%0d act=%0h%0h%0h%0h/%0h exp=10%0h0/%0h", b, m0_rvalid, m1_rvalid,
                     m0_rlast, m1_rlast, m0_rdata, (b == 15), d); end
         nxt();
      end
      drive_idle();
   endtask

   task automatic test_contention();
      int hs_cyc[$];
      logic [5:0] hs_id[$];
      logic [31:0] hs_ad[$];
      int quiet = 0;
      do_reset();
      m0_araddr = 32'hA000; m1_araddr = 32'hB000; m0_arvalid = 1; m1_arvalid = 1; arready = 1;
      for (int c = 0; c < 30 && hs_id.size() < 8; c++) begin
         #3;
         if (arvalid && arready) begin hs_cyc.push_back(c); hs_id.push_back(arid); hs_ad.push_back(araddr); end
         nxt();
      end
      total++; if (hs_id.size() != 8) begin bad++; $display("FAIL cont_count act=%0d exp=8", hs_id.size()); end
      for (int k = 0; k < hs_id.size(); k++) begin
         total++; if (hs_id[k] !== 6'(k % 2) || hs_ad[k] !== ((k % 2) ? 32'hB000 : 32'hA000)) begin bad++;
            $display("FAIL cont_grant%0d act=%0h/%0h exp=%0h", k, hs_id[k], hs_ad[k], k % 2); end
         if (k > 0) begin
            total++; if (hs_cyc[k] - hs_cyc[k-1] != 2) begin bad++;
               $display("FAIL cont_spacing%0d act=%0d exp=2", k, hs_cyc[k] - hs_cyc[k-1]); end
         end
      end
      // Both ports now hold MAXOUT bursts with no data returned.
      for (int c = 0; c < 5; c++) begin #3; quiet += int'(arvalid); nxt(); end
      total++; if (quiet != 0) begin bad++; $display("FAIL cont_blocked act=%0d exp=0", quiet); end
      drive_idle();
   endtask

   task automatic test_outstanding();
      int n0 = 0, n1 = 0, quiet = 0, c;
      do_reset();
      m0_arvalid = 1; arready = 1;
      for (c = 0; c < 20 && n0 < MAXOUT; c++) begin #3; if (arvalid) n0++; nxt(); end
      total++; if (n0 != MAXOUT) begin bad++; $display("FAIL out_m0_fill act=%0d exp=%0d", n0, MAXOUT); end
      for (c = 0; c < 4; c++) begin #3; quiet += int'(arvalid); nxt(); end
      total++; if (quiet != 0) begin bad++; $display("FAIL out_m0_skip act=%0d exp=0", quiet); end
      m1_arvalid = 1;
      for (c = 0; c < 20 && n1 < 3; c++) begin
         #3;
         if (arvalid) begin
            n1++;
            total++; if (arid !== 6'd1) begin bad++; $display("FAIL out_m1_grant act=%0h exp=1", arid); end
         end
         nxt();
      end
      total++; if (n1 != 3) begin bad++; $display("FAIL out_m1_count act=%0d exp=3", n1); end
      m1_arvalid = 0; rvalid = 1; rlast = 1; rid = 0; nxt();
      rvalid = 0; rlast = 0; m1_arvalid = 1; #3;
      nxt(); #3;
      total++; if ({arvalid, arid} !== {1'b1, 6'd0}) begin bad++;
         $display("FAIL out_m0_regrant act=%0h/%0h exp=1/0", arvalid, arid); end
      nxt(); drive_idle();
   endtask

   task automatic test_simul();
      int n = 0, c;
      logic r0, l0;
      do_reset();
      m0_arvalid = 1; arready = 1;
      for (c = 0; c < 20 && n < 2; c++) begin #3; if (arvalid) n++; nxt(); end
      arready = 0;
      for (c = 0; c < 5 && !arvalid; c++) nxt();
      arready = 1; rvalid = 1; rlast = 1; rid = 0; #3;
      r0 = m0_arready; l0 = m0_rlast;
      total++; if ({r0, l0} !== 2'b11) begin bad++; $display("FAIL simul_same_cycle act=%0b%0b exp=11", r0, l0); end
      nxt();
      rvalid = 0; rlast = 0; n = 0;
      for (c = 0; c < 16; c++) begin #3; n += int'(arvalid && arready); nxt(); end
      total++; if (n != 2) begin bad++; $display("FAIL simul_out0_kept act=%0d exp=2", n); end
      m0_arvalid = 0; nxt();
      rvalid = 1; rlast = 1; rid = 1; nxt();
      rvalid = 0; rlast = 0; m1_arvalid = 1; n = 0;
      for (c = 0; c < 16; c++) begin #3; n += int'(arvalid && arready); nxt(); end
      total++; if (n != MAXOUT) begin bad++; $display("FAIL simul_stray_sat act=%0d exp=%0d", n, MAXOUT); end
      drive_idle();
   endtask

   task automatic test_reset_mid();
      int n = 0, c;
      logic [5:0] ids[$];
      do_reset();
      m1_arvalid = 1; arready = 1;
      for (c = 0; c < 20 && n < MAXOUT; c++) begin #3; if (arvalid) n++; nxt(); end
      m1_arvalid = 0; m0_arvalid = 1; arready = 0;
      nxt(); #3;
      total++; if ({arvalid, arid} !== {1'b1, 6'd0}) begin bad++;
         $display("FAIL rmid_issue act=%0h/%0h exp=1/0", arvalid, arid); end
      nxt();
      reset = 1; rvalid = 1; rid = 6'd1; rdata = 64'h1234; #3;
      total++; if ({m1_rvalid, m0_rvalid} !== 2'b10) begin bad++;
         $display("FAIL rmid_route act=%0b%0b exp=10", m1_rvalid, m0_rvalid); end
      nxt();
      reset = 0; rvalid = 0; m0_arvalid = 1; m1_arvalid = 1; #3;
      total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL rmid_drop act=%0h exp=0", arvalid); end
      arready = 1;
      for (c = 0; c < 10 && ids.size() < 2; c++) begin #3; if (arvalid) ids.push_back(arid); nxt(); end
      total++; if (ids.size() != 2 || ids[0] !== 6'd0 || ids[1] !== 6'd1) begin bad++;
         $display("FAIL rmid_tie n=%0d exp=2 grants 0 then 1", ids.size()); end
      drive_idle();
   endtask

`ifdef RDARB_STATS_EN
   task automatic test_stats();
      int st = 0;
      do_reset();
      for (int b = 0; b < 48; b++) begin
         rvalid = 1; rid = (b < 32) ? 6'd1 : 6'd0; rlast = (b % 16 == 15); nxt();
      end
      rvalid = 0; rlast = 0; #3;
      total++; if ({beats1, beats0} !== {32'd32, 32'd16}) begin bad++;
         $display("FAIL stats_beats act=%0d/%0d exp=32/16", beats1, beats0); end
      m0_arvalid = 1; nxt(); m0_arvalid = 0;
      for (int c = 0; c < 5; c++) begin #3; st += int'(stall); nxt(); end
      arready = 1; #3; st += int'(stall); nxt();
      total++; if (st != 5) begin bad++; $display("FAIL stats_stall act=%0d exp=5", st); end
      drive_idle();
   endtask
`endif

   typedef struct {logic id; int len;} burst_t;

   // Randomized traffic; the model tracks pending requests, issued bursts and
   // per-port outstanding counts at transaction level.
   task automatic test_random();
      burst_t bq[$];
      int mo[2];
      bit mav, mgnt, hs, el[2], g;
      logic [31:0] maddr;
      logic [3:0] mlen;
      logic rq_v[2];
      logic [31:0] rq_a[2];
      logic [3:0] rq_l[2];
      int beat = 0;
      do_reset();
      mo[0] = 0; mo[1] = 0; mav = 0; mgnt = 1; maddr = 0; mlen = 0;
      for (int n = 0; n < 2; n++) begin rq_v[n] = 0; rq_a[n] = 0; rq_l[n] = 0; end
      for (int cyc = 0; cyc < 1500; cyc++) begin
         m0_arvalid = rq_v[0]; m0_araddr = rq_a[0]; m0_arlen = rq_l[0];
         m1_arvalid = rq_v[1]; m1_araddr = rq_a[1]; m1_arlen = rq_l[1];
         arready = ($urandom_range(0, 3) != 0);
         rresp = 2'($urandom_range(0, 3));
         if (bq.size() > 0 && $urandom_range(0, 2) != 0) begin
            rvalid = 1; rid = {5'($urandom_range(0, 31)), bq[0].id};
            rlast = (beat == bq[0].len); rdata = {$urandom, $urandom};
         end else begin
            rvalid = 0; rlast = 0; rid = 6'($urandom_range(0, 63));
         end
         #3;
         total++; if (arvalid !== mav) begin bad++; $display("FAIL rnd_arvalid c=%0d act=%0h exp=%0h", cyc, arvalid, mav); end
         if (mav) begin
            total++; if ({araddr, arid, arlen} !== {maddr, 5'b0, mgnt, mlen}) begin bad++;
               $display("FAIL rnd_ar c=%0d act=%0h/%0h/%0h exp=%0h/%0h/%0h", cyc, araddr, arid, arlen, maddr, mgnt, mlen); end
         end
         total++; if ({m0_arready, m1_arready} !== {mav && arready && !mgnt, mav && arready && mgnt}) begin bad++;
            $display("FAIL rnd_arready c=%0d act=%0b%0b", cyc, m0_arready, m1_arready); end
         total++;
         if ({m0_rvalid, m0_rlast, m1_rvalid, m1_rlast} !==
             {rvalid && !rid[0], rlast && !rid[0], rvalid && rid[0], rlast && rid[0]} ||
             (rvalid && (m0_rdata !== rdata || m1_rdata !== rdata))) begin bad++;
            $display("FAIL rnd_r c=%0d act=%0b%0b%0b%0b rid=%0h", cyc, m0_rvalid, m0_rlast, m1_rvalid, m1_rlast, rid); end
         // Model advance for the coming clock edge.
         hs = mav && arready;
         for (int n = 0; n < 2; n++) el[n] = rq_v[n] && (mo[n] < MAXOUT);
         for (int n = 0; n < 2; n++) begin
            if (rvalid && rlast && rid[0] == 1'(n) && !(hs && mgnt == 1'(n))) mo[n] = (mo[n] > 0) ? mo[n] - 1 : 0;
            else if (hs && mgnt == 1'(n) && !(rvalid && rlast && rid[0] == 1'(n))) mo[n]++;
         end
         if (hs) begin
            mav = 0;
            bq.push_back('{id: mgnt, len: int'(mlen)});
            rq_v[mgnt] = 0;
         end else if (!mav && (el[0] || el[1])) begin
            g = (el[0] && el[1]) ? !mgnt : el[1];
            mav = 1; mgnt = g; maddr = rq_a[g]; mlen = rq_l[g];
         end
         for (int n = 0; n < 2; n++) begin
            if (!rq_v[n] && $urandom_range(0, 1) == 1) begin
               rq_v[n] = 1; rq_a[n] = $urandom & 32'hFFFF_FFF8; rq_l[n] = 4'($urandom_range(0, 15));
            end
         end
         if (rvalid) begin
            if (rlast) begin void'(bq.pop_front()); beat = 0; end
            else beat++;
         end
         nxt();
      end
      drive_idle();
   endtask

   initial begin
      reset = 1;
      drive_idle();
      test_reset();
      test_single();
      test_contention();
      test_outstanding();
      test_simul();
      test_reset_mid();
`ifdef RDARB_STATS_EN
      test_stats();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
